// File: rtl/inert_rd_seq.sv
// Inertial-sensor read sequencer: issues a setup command after reset, then on each
// data-ready edge reads every channel over SPI, offset-corrects it, and can self-calibrate.
module inert_rd_seq #(
  parameter int          NUM_CH    = 6,
  parameter int          CAL_SHIFT = 8,
  parameter logic [6:0]  ADDR_BASE = 7'h22,
  parameter logic [15:0] INIT_CMD  = 16'h0D02
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 INT,
  input  logic                 strt_cal,
  input  logic                 done,
  input  logic [15:0]          rd_data,
  output logic                 wrt,
  output logic [15:0]          cmd,
  output logic [NUM_CH*16-1:0] data,
  output logic                 vld,
  output logic                 cal_done,
  output logic                 busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 16 + CAL_SHIFT;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD_LO, S_RD_HI, S_UPDATE} state_t;

  state_t            state_q, state_d;
  logic              wait_q, wait_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              wrt_q, wrt_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cap_lo, cap_hi, start, upd;

  logic              int_meta_q, int_sync_q, int_prev_q, int_edge;
  logic              pend_q, cal_req_q, cal_active_q;
  logic [CAL_SHIFT-1:0] cnt_q;
  logic              vld_q, cal_done_q;

  logic [15:0]             raw_q    [NUM_CH];
  logic [15:0]             data_q   [NUM_CH];
  logic [15:0]             offset_q [NUM_CH];
  logic signed [ACC_W-1:0] acc_q    [NUM_CH];
  logic signed [ACC_W-1:0] acc_sum  [NUM_CH];
  logic [16:0]             diff     [NUM_CH];
  logic [15:0]             sat_val  [NUM_CH];

  logic [6:0] lo_addr, hi_addr;
  logic       unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:8];
  assign int_edge     = int_sync_q & ~int_prev_q;
  assign lo_addr      = ADDR_BASE + (7'(ch_q) << 1);
  assign hi_addr      = lo_addr + 7'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      wait_q  <= 1'b0;
      ch_q    <= '0;
      wrt_q   <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ch_q    <= ch_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ch_d    = ch_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    cap_lo  = 1'b0;
    cap_hi  = 1'b0;
    start   = 1'b0;
    upd     = 1'b0;
    case (state_q)
      S_INIT: begin
        if (!wait_q) begin
          wrt_d = 1'b1; cmd_d = INIT_CMD; wait_d = 1'b1;
        end else if (done) begin
          wait_d = 1'b0; state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (int_edge || pend_q) begin
          start = 1'b1; ch_d = '0; state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        if (!wait_q) begin
          wrt_d = 1'b1; cmd_d = {1'b1, lo_addr, 8'h00}; wait_d = 1'b1;
        end else if (done) begin
          cap_lo = 1'b1; wait_d = 1'b0; state_d = S_RD_HI;
        end
      end
      S_RD_HI: begin
        if (!wait_q) begin
          wrt_d = 1'b1; cmd_d = {1'b1, hi_addr, 8'h00}; wait_d = 1'b1;
        end else if (done) begin
          cap_hi = 1'b1; wait_d = 1'b0;
          if (ch_q == CH_W'(NUM_CH - 1)) state_d = S_UPDATE;
          else begin
            ch_d = ch_q + 1'b1; state_d = S_RD_LO;
          end
        end
      end
      S_UPDATE: begin
        upd = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Per-channel arithmetic: accumulate, and 17-bit signed subtract with clamping.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      acc_sum[i] = acc_q[i] + {{CAL_SHIFT{raw_q[i][15]}}, raw_q[i]};
      diff[i]    = {raw_q[i][15], raw_q[i]} - {offset_q[i][15], offset_q[i]};
      if (diff[i][16] != diff[i][15]) sat_val[i] = diff[i][16] ? 16'h8000 : 16'h7FFF;
      else                            sat_val[i] = diff[i][15:0];
    end
  end

  // NOTE: the raw capture array carries no reset; it is always fully rewritten before UPDATE reads it.
  always_ff @(posedge clk) begin
    if (cap_lo) raw_q[ch_q][7:0]  <= rd_data[7:0];
    if (cap_hi) raw_q[ch_q][15:8] <= rd_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta_q   <= 1'b0;
      int_sync_q   <= 1'b0;
      int_prev_q   <= 1'b0;
      pend_q       <= 1'b0;
      cal_req_q    <= 1'b0;
      cal_active_q <= 1'b0;
      cnt_q        <= '0;
      vld_q        <= 1'b0;
      cal_done_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i]   <= '0;
        offset_q[i] <= '0;
        acc_q[i]    <= '0;
      end
    end else begin
      int_meta_q <= INT;
      int_sync_q <= int_meta_q;
      int_prev_q <= int_sync_q;
      vld_q      <= 1'b0;
      cal_done_q <= 1'b0;

      // One pending slot remembers an edge seen while a set is in progress.
      if (start)                            pend_q <= 1'b0;
      else if (int_edge && state_q != S_IDLE) pend_q <= 1'b1;

      if (start && cal_req_q) begin
        cal_active_q <= 1'b1;
        cal_req_q    <= 1'b0;
        cnt_q        <= '0;
        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      end else if (strt_cal && !cal_active_q) begin
        cal_req_q <= 1'b1;
      end

      if (upd) begin
        if (cal_active_q) begin
          cnt_q <= cnt_q + 1'b1;
          for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_sum[i];
          if (&cnt_q) begin
            for (int i = 0; i < NUM_CH; i++) offset_q[i] <= 16'(acc_sum[i] >>> CAL_SHIFT);
            cal_done_q   <= 1'b1;
            cal_active_q <= 1'b0;
          end
        end else begin
          for (int i = 0; i < NUM_CH; i++) data_q[i] <= sat_val[i];
          vld_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) data[i*16 +: 16] = data_q[i];
  end

  assign wrt      = wrt_q;
  assign cmd      = cmd_q;
  assign vld      = vld_q;
  assign cal_done = cal_done_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_inert_rd_seq.sv
// Directed bench for inert_rd_seq (2 channels, 4-set calibration) with a small SPI
// responder that serves bytes from the current raw0/raw1 values.
module tb_inert_rd_seq;

  logic        clk, rst, INT, strt_cal, done, wrt, vld, cal_done, busy;
  logic        resp_done, stray_done;
  logic [15:0] rd_data, cmd;
  logic [31:0] data;

  logic [15:0] raw0, raw1;
  logic [15:0] cmd_log[$];
  int          wrt_cnt, vld_cnt, cd_cnt;
  int          n_pass, n_total;

  typedef struct {
    logic [15:0] raw0, raw1, exp0, exp1;
    bit          strt;
    int          exp_vld, exp_cd;
  } vec_t;

  vec_t vecs [14];

  assign done = resp_done | stray_done;

  inert_rd_seq #(.NUM_CH(2), .CAL_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .INT(INT), .strt_cal(strt_cal), .done(done),
    .rd_data(rd_data), .wrt(wrt), .cmd(cmd), .data(data), .vld(vld),
    .cal_done(cal_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] pick_byte(input logic [15:0] c);
    logic [6:0] idx;
    idx = c[14:8] - 7'h22;
    case (idx)
      7'd0:    return raw0[7:0];
      7'd1:    return raw0[15:8];
      7'd2:    return raw1[7:0];
      7'd3:    return raw1[15:8];
      default: return 8'h5A;
    endcase
  endfunction

  // SPI responder: done two cycles after wrt; abandons the transfer if rst appears.
  initial begin
    resp_done = 1'b0;
    rd_data   = '0;
    forever begin
      @(negedge clk);
      if (wrt && !rst) begin
        bit aborted;
        aborted = 1'b0;
        cmd_log.push_back(cmd);
        wrt_cnt++;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          rd_data   = {8'hEE, pick_byte(cmd)};
          resp_done = 1'b1;
          @(negedge clk);
          resp_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (vld)      vld_cnt++;
    if (cal_done) cd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    if (busy !== 1'b1) begin
      n_total++;
      $display("FAIL %s timeout: busy=%b, expected 1", tag, busy);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    if (busy !== 1'b0) begin
      n_total++;
      $display("FAIL %s timeout: busy=%b, expected 0", tag, busy);
    end
  endtask

  task automatic pulse_int(input int n);
    INT = 1'b1;
    repeat (n) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic run_set(input logic [15:0] r0, input logic [15:0] r1);
    raw0 = r0;
    raw1 = r1;
    pulse_int(3);
    wait_busy(20, "set_start");
    wait_idle(200, "set_end");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int          base, v0, c0, w0;
    logic [15:0] exp_cmds [4];

    rst = 1'b1; INT = 1'b0; strt_cal = 1'b0; stray_done = 1'b0;
    raw0 = '0; raw1 = '0;
    exp_cmds[0] = 16'hA200; exp_cmds[1] = 16'hA300;
    exp_cmds[2] = 16'hA400; exp_cmds[3] = 16'hA500;

    //            raw0      raw1      exp0      exp1     strt  vld cd
    vecs[0]  = '{16'h1234, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1, 0};
    vecs[1]  = '{16'd100,  16'hFFFC, 16'h1234, 16'hABCD, 1'b1, 0, 0};
    vecs[2]  = '{16'd102,  16'hFFFC, 16'h1234, 16'hABCD, 1'b0, 0, 0};
    vecs[3]  = '{16'd98,   16'hFFFC, 16'h1234, 16'hABCD, 1'b0, 0, 0};
    vecs[4]  = '{16'd100,  16'hFFFC, 16'h1234, 16'hABCD, 1'b0, 0, 1};
    vecs[5]  = '{16'd150,  16'h0000, 16'h0032, 16'h0004, 1'b0, 1, 0};
    vecs[6]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1, 0};
    vecs[7]  = '{16'h0000, 16'h0000, 16'hFF9C, 16'h0004, 1'b0, 1, 0};
    vecs[8]  = '{16'hFF9C, 16'hFFFD, 16'hFF9C, 16'h0004, 1'b1, 0, 0};
    vecs[9]  = '{16'hFF9C, 16'hFFFD, 16'hFF9C, 16'h0004, 1'b0, 0, 0};
    vecs[10] = '{16'hFF9C, 16'hFFFD, 16'hFF9C, 16'h0004, 1'b1, 0, 0};
    vecs[11] = '{16'hFF9C, 16'hFFFE, 16'hFF9C, 16'h0004, 1'b0, 0, 1};
    vecs[12] = '{16'h7FBC, 16'h000A, 16'h7FFF, 16'h000D, 1'b0, 1, 0};
    vecs[13] = '{16'h8000, 16'h8000, 16'h8064, 16'h8003, 1'b0, 1, 0};

    // Reset values and the single setup command.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_wrt",  32'(wrt),  32'd0);
    check("rst_cmd",  32'(cmd),  32'd0);
    check("rst_data", data,      32'd0);
    check("rst_vld",  32'(vld),  32'd0);
    rst = 1'b0;
    wait_idle(50, "init");
    check("init_wrt_n", 32'(cmd_log.size()), 32'd1);
    check("init_cmd",   32'(cmd_log[0]), 32'h0D02);
    repeat (20) @(negedge clk);
    check("idle_no_wrt", 32'(wrt_cnt), 32'd1);

    // Table: normal sets, two calibrations and saturation corners.
    foreach (vecs[i]) begin
      base = cmd_log.size(); v0 = vld_cnt; c0 = cd_cnt;
      if (vecs[i].strt) begin
        strt_cal = 1'b1;
        @(negedge clk);
        strt_cal = 1'b0;
      end
      run_set(vecs[i].raw0, vecs[i].raw1);
      check($sformatf("v%0d_ch0", i), 32'(data[15:0]),  32'(vecs[i].exp0));
      check($sformatf("v%0d_ch1", i), 32'(data[31:16]), 32'(vecs[i].exp1));
      check($sformatf("v%0d_vld", i), 32'(vld_cnt - v0), 32'(vecs[i].exp_vld));
      check($sformatf("v%0d_cal_done", i), 32'(cd_cnt - c0), 32'(vecs[i].exp_cd));
      if (i == 0) begin
        check("v0_cmd_n", 32'(cmd_log.size() - base), 32'd4);
        for (int k = 0; k < 4; k++)
          check($sformatf("v0_cmd%0d", k), 32'(cmd_log[base + k]), 32'(exp_cmds[k]));
      end
    end

    // Stray done while idle must not start anything.
    w0 = wrt_cnt;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (10) @(negedge clk);
    check("stray_done_wrt",  32'(wrt_cnt - w0), 32'd0);
    check("stray_done_busy", 32'(busy), 32'd0);

    // INT held high: one set only.
    v0 = vld_cnt; w0 = wrt_cnt;
    raw0 = 16'h0001; raw1 = 16'h0001;
    INT = 1'b1;
    repeat (70) @(negedge clk);
    INT = 1'b0;
    repeat (10) @(negedge clk);
    wait_idle(100, "held_int");
    check("held_vld_n", 32'(vld_cnt - v0), 32'd1);
    check("held_wrt_n", 32'(wrt_cnt - w0), 32'd4);
    check("held_ch0",   32'(data[15:0]),  32'h0065);
    check("held_ch1",   32'(data[31:16]), 32'h0004);

    // Two edges during a set: exactly one extra set.
    v0 = vld_cnt; w0 = wrt_cnt;
    pulse_int(3);
    wait_busy(20, "dbl_start");
    repeat (2) @(negedge clk);
    pulse_int(2);
    repeat (2) @(negedge clk);
    pulse_int(2);
    repeat (80) @(negedge clk);
    wait_idle(100, "dbl_end");
    repeat (2) @(negedge clk);
    check("dbl_vld_n", 32'(vld_cnt - v0), 32'd2);
    check("dbl_wrt_n", 32'(wrt_cnt - w0), 32'd8);

    // Reset during the last RD_HI abandons the set and clears offsets.
    base = cmd_log.size();
    raw0 = 16'h1111; raw1 = 16'h2222;
    pulse_int(3);
    begin
      int k = 0;
      while (cmd_log.size() < base + 4 && k < 100) begin @(negedge clk); k++; end
      check("rst_mid_reach_rdhi", 32'(cmd_log.size() - base), 32'd4);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_data", data, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    wait_idle(50, "rst_mid_init");
    repeat (5) @(negedge clk);
    check("rst_mid_cmd_n", 32'(cmd_log.size() - base), 32'd5);
    check("rst_mid_cmd",   32'(cmd_log[base + 4]), 32'h0D02);
    v0 = vld_cnt;
    run_set(16'h0123, 16'hFFFF);
    check("post_rst_ch0", 32'(data[15:0]),  32'h0123);
    check("post_rst_ch1", 32'(data[31:16]), 32'hFFFF);
    check("post_rst_vld", 32'(vld_cnt - v0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
